// File: rtl/ee354_ssd_driver.sv
// ee354_ssd_driver: seven-segment display driver.
// Captures a binary value on Load and converts it to hex digits (one cycle) or
// decimal digits (sequential double dabble, one input bit per clock). Leading
// zeros can be blanked, and values that do not fit show dashes on every digit.
// The committed digits are time-multiplexed onto An/Cathodes, both registered.
// Optional feature macro: SSD_DP_EN adds the Dp_Sel input, which drives the
// decimal point of each digit.
module ee354_ssd_driver #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned VAL_W    = 8,
    parameter int unsigned SCAN_DIV = 18
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [VAL_W-1:0]    Value,
    input  logic                Load,
    input  logic                Hex_Mode,
    input  logic                Blank_En,
`ifdef SSD_DP_EN
    input  logic [N_DIGITS-1:0] Dp_Sel,
`endif
    output logic                Busy,
    output logic [7:0]          An,
    output logic [7:0]          Cathodes
);

    localparam int unsigned DIG_W = 4 * N_DIGITS;
    // Hex overflow check needs the value padded up to at least the digit width.
    localparam int unsigned EXT_W = (VAL_W > DIG_W) ? VAL_W : DIG_W;

    localparam logic [4:0] LAST_BIT = 5'(VAL_W - 1);
    localparam logic [2:0] LAST_IDX = 3'(N_DIGITS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHex  = 2'd1;
    localparam logic [1:0] StDec  = 2'd2;

    // Conversion state
    logic [1:0]       state_q, state_d;
    logic [VAL_W-1:0] val_q;
    logic             blank_en_q;
    logic [DIG_W-1:0] bcd_q;
    logic             ovf_acc_q;
    logic [4:0]       bit_cnt_q;

    // Displayed state, only replaced as a whole at conversion end
    logic [DIG_W-1:0] dig_q;
    logic [7:0]       blank_q;
    logic             ovf_q;

    // Scan state
    logic [SCAN_DIV-1:0] presc_q;
    logic [2:0]          idx_q;
    logic [7:0]          an_q;
    logic [7:0]          cath_q;

`ifdef SSD_DP_EN
    logic [N_DIGITS-1:0] dp_sel_q;
    logic [7:0]          dp_q;
    logic [7:0]          dp_ext;
`endif

    logic             accept;
    logic             last_bit;
    logic             commit;
    logic [DIG_W-1:0] bcd_adj;
    logic [DIG_W-1:0] bcd_shift;
    logic             shift_out;
    logic [EXT_W-1:0] val_ext;
    logic [DIG_W-1:0] hex_dig;
    logic             hex_ovf;
    logic [DIG_W-1:0] new_dig;
    logic             new_ovf;
    logic [7:0]       new_blank;
    logic             seen_nz;
    logic [3:0]       cur_nib;
    logic [7:0]       cur_seg;
    logic             dp_n;
    logic [7:0]       an_d;
    logic [7:0]       cath_d;

    // Active-low segment pattern {a,b,c,d,e,f,g,dp} with dp off.
    function automatic logic [7:0] seg_lut(input logic [3:0] nib);
        logic [7:0] seg;
        unique case (nib)
            4'h0: seg = 8'b00000011;
            4'h1: seg = 8'b10011111;
            4'h2: seg = 8'b00100101;
            4'h3: seg = 8'b00001101;
            4'h4: seg = 8'b10011001;
            4'h5: seg = 8'b01001001;
            4'h6: seg = 8'b01000001;
            4'h7: seg = 8'b00011111;
            4'h8: seg = 8'b00000001;
            4'h9: seg = 8'b00001001;
            4'hA: seg = 8'b00010001;
            4'hB: seg = 8'b11000001;
            4'hC: seg = 8'b01100011;
            4'hD: seg = 8'b10000101;
            4'hE: seg = 8'b01100001;
            4'hF: seg = 8'b01110001;
        endcase
        return seg;
    endfunction

    assign accept   = Load && (state_q == StIdle);
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign commit   = (state_q == StHex) || ((state_q == StDec) && last_bit);
    assign Busy     = (state_q != StIdle);

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_out = bcd_adj[DIG_W-1];
        bcd_shift = {bcd_adj[DIG_W-2:0], val_q[VAL_W-1]};
    end

    // Hex digits are the raw nibbles; any set bit above the digits overflows.
    always_comb begin
        val_ext              = '0;
        val_ext[VAL_W-1:0]   = val_q;
        hex_dig              = val_ext[DIG_W-1:0];
        hex_ovf              = 1'b0;
        for (int unsigned i = DIG_W; i < EXT_W; i++) begin
            hex_ovf = hex_ovf | val_ext[i];
        end
    end

    // Select the finished result and blank zeros above the top non-zero digit.
    always_comb begin
        new_dig   = (state_q == StHex) ? hex_dig : bcd_shift;
        new_ovf   = (state_q == StHex) ? hex_ovf : (ovf_acc_q | shift_out);
        new_blank = '0;
        seen_nz   = 1'b0;
        // Digit 0 is never blanked so a zero value still reads "0".
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            if (new_dig[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            new_blank[i] = blank_en_q & ~seen_nz;
        end
    end

    // Conversion sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (Load) begin
                    state_d = Hex_Mode ? StHex : StDec;
                end
            end
            StHex: state_d = StIdle;
            StDec: begin
                if (last_bit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Conversion registers: capture inputs on accept, iterate while decimal.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            val_q      <= '0;
            blank_en_q <= 1'b0;
            bcd_q      <= '0;
            ovf_acc_q  <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                val_q      <= Value;
                blank_en_q <= Blank_En;
                bcd_q      <= '0;
                ovf_acc_q  <= 1'b0;
                bit_cnt_q  <= '0;
            end else if (state_q == StDec) begin
                val_q     <= val_q << 1;
                bcd_q     <= bcd_shift;
                ovf_acc_q <= ovf_acc_q | shift_out;
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
        end
    end

`ifdef SSD_DP_EN
    always_comb begin
        dp_ext                 = '0;
        dp_ext[N_DIGITS-1:0]   = dp_sel_q;
    end

    // Decimal-point selection travels with the conversion and commits with it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dp_sel_q <= '0;
            dp_q     <= '0;
        end else begin
            if (accept) begin
                dp_sel_q <= Dp_Sel;
            end
            if (commit) begin
                dp_q <= dp_ext;
            end
        end
    end
`endif

    // Displayed digits, blank mask and overflow flag update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dig_q   <= '0;
            blank_q <= '0;
            ovf_q   <= 1'b0;
        end else if (commit) begin
            dig_q   <= new_dig;
            blank_q <= new_blank;
            ovf_q   <= new_ovf;
        end
    end

    // Prescaler and digit index; the index wraps at N_DIGITS-1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    // Anode and cathode pattern for the currently scanned digit.
    always_comb begin
        cur_nib = dig_q[4*idx_q +: 4];
        cur_seg = seg_lut(cur_nib);
`ifdef SSD_DP_EN
        dp_n = ~dp_q[idx_q];
`else
        dp_n = 1'b1;
`endif
        an_d = ~(8'h01 << idx_q);
        if (ovf_q) begin
            cath_d = {7'b1111110, dp_n};
        end else if (blank_q[idx_q]) begin
            cath_d = {7'b1111111, dp_n};
        end else begin
            cath_d = {cur_seg[7:1], dp_n};
        end
    end

    // Registered outputs, dark while in reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_q   <= 8'hFF;
            cath_q <= 8'hFF;
        end else begin
            an_q   <= an_d;
            cath_q <= cath_d;
        end
    end

    assign An       = an_q;
    assign Cathodes = cath_q;

endmodule

// File: tb/tb_ee354_ssd_driver.sv
// Testbench for ee354_ssd_driver: table of load vectors on a 4-digit and a
// 2-digit instance, plus hand-written sequences for busy handling, scan order
// and reset during a conversion on a 3-digit instance.
module tb_ee354_ssd_driver;

    localparam logic [7:0] S0 = 8'h03, S1 = 8'h9F, S2 = 8'h25, S3 = 8'h0D;
    localparam logic [7:0] S5 = 8'h49, S7 = 8'h1F, S9 = 8'h09, SA = 8'h11;
    localparam logic [7:0] SB = 8'hC1, SF = 8'h71, BL = 8'hFF, DASH = 8'hFD;

    logic        clk;
    logic        Reset;

    logic [7:0]  v4, v3;
    logic [11:0] v2;
    logic        l4, h4, b4, l2, h2, b2, l3, h3, b3;
    logic        busy4, busy2, busy3;
    logic [7:0]  an4, an2, an3, cat4, cat2, cat3;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap [8];

    typedef struct {
        int          sel;
        logic [11:0] value;
        logic        hex;
        logic        blank;
        int          busy;
        logic [31:0] cath;
    } vec_t;

    vec_t vecs [14];

    ee354_ssd_driver #(.N_DIGITS(4), .VAL_W(8), .SCAN_DIV(2)) u_dut4 (
        .Clk(clk), .Reset(Reset), .Value(v4), .Load(l4), .Hex_Mode(h4), .Blank_En(b4),
`ifdef SSD_DP_EN
        .Dp_Sel(4'b0),
`endif
        .Busy(busy4), .An(an4), .Cathodes(cat4)
    );

    ee354_ssd_driver #(.N_DIGITS(2), .VAL_W(12), .SCAN_DIV(2)) u_dut2 (
        .Clk(clk), .Reset(Reset), .Value(v2), .Load(l2), .Hex_Mode(h2), .Blank_En(b2),
`ifdef SSD_DP_EN
        .Dp_Sel(2'b0),
`endif
        .Busy(busy2), .An(an2), .Cathodes(cat2)
    );

    ee354_ssd_driver #(.N_DIGITS(3), .VAL_W(8), .SCAN_DIV(2)) u_dut3 (
        .Clk(clk), .Reset(Reset), .Value(v3), .Load(l3), .Hex_Mode(h3), .Blank_En(b3),
`ifdef SSD_DP_EN
        .Dp_Sel(3'b0),
`endif
        .Busy(busy3), .An(an3), .Cathodes(cat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ndig(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 2 : 3);
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy4 : ((sel == 1) ? busy2 : busy3);
    endfunction

    function automatic logic [7:0] an_of(input int sel);
        return (sel == 0) ? an4 : ((sel == 1) ? an2 : an3);
    endfunction

    function automatic logic [7:0] cat_of(input int sel);
        return (sel == 0) ? cat4 : ((sel == 1) ? cat2 : cat3);
    endfunction

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [11:0] v, input logic hx, input logic bl,
                         input logic ld);
        case (sel)
            0: begin v4 = v[7:0]; h4 = hx; b4 = bl; l4 = ld; end
            1: begin v2 = v;      h2 = hx; b2 = bl; l2 = ld; end
            default: begin v3 = v[7:0]; h3 = hx; b3 = bl; l3 = ld; end
        endcase
    endtask

    task automatic set_load(input int sel, input logic ld);
        case (sel)
            0: l4 = ld;
            1: l2 = ld;
            default: l3 = ld;
        endcase
    endtask

    // Count negedges with Busy high, starting at the current negedge.
    task automatic wait_busy(input int sel, output int cnt);
        cnt = 0;
        while (busy_of(sel) && cnt < 64) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Pulse Load for one edge (called at a negedge), then count busy cycles.
    task automatic load_count(input int sel, input logic [11:0] v, input logic hx,
                              input logic bl, output int cnt);
        drive(sel, v, hx, bl, 1'b1);
        @(negedge clk);
        set_load(sel, 1'b0);
        wait_busy(sel, cnt);
    endtask

    // Watch a full scan round and record the cathodes shown for each anode.
    task automatic capture(input int sel);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) cap[i] = 'x;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4 * ndig(sel) + 8; k++) begin
            a = an_of(sel);
            for (int i = 0; i < ndig(sel); i++) begin
                if (a == ~(8'h01 << i)) cap[i] = cat_of(sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_digits(input string name, input int sel, input logic [31:0] exp);
        for (int i = 0; i < ndig(sel); i++) begin
            check8($sformatf("%s_d%0d", name, i), cap[i], exp[8*i +: 8]);
        end
    endtask

    initial begin
        int         cnt;
        logic [7:0] prev;
        logic [7:0] exp_an;
        bit         found;

        vecs[0]  = '{0, 12'd225,  1'b0, 1'b1, 8,  {BL, S2, S2, S5}};
        vecs[1]  = '{0, 12'h0A3,  1'b1, 1'b0, 1,  {S0, S0, SA, S3}};
        vecs[2]  = '{0, 12'd0,    1'b0, 1'b1, 8,  {BL, BL, BL, S0}};
        vecs[3]  = '{0, 12'd0,    1'b1, 1'b1, 1,  {BL, BL, BL, S0}};
        vecs[4]  = '{0, 12'd7,    1'b0, 1'b0, 8,  {S0, S0, S0, S7}};
        vecs[5]  = '{0, 12'h0F0,  1'b1, 1'b1, 1,  {BL, BL, SF, S0}};
        vecs[6]  = '{0, 12'd255,  1'b0, 1'b1, 8,  {BL, S2, S5, S5}};
        vecs[7]  = '{0, 12'h01B,  1'b1, 1'b1, 1,  {BL, BL, S1, SB}};
        vecs[8]  = '{0, 12'd100,  1'b0, 1'b1, 8,  {BL, S1, S0, S0}};
        vecs[9]  = '{1, 12'd100,  1'b0, 1'b1, 12, {16'h0, DASH, DASH}};
        vecs[10] = '{1, 12'd99,   1'b0, 1'b1, 12, {16'h0, S9, S9}};
        vecs[11] = '{1, 12'h123,  1'b1, 1'b0, 1,  {16'h0, DASH, DASH}};
        vecs[12] = '{1, 12'h0FF,  1'b1, 1'b1, 1,  {16'h0, SF, SF}};
        vecs[13] = '{1, 12'd5,    1'b0, 1'b1, 12, {16'h0, BL, S5}};

        Reset = 1'b1;
        drive(0, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(1, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(2, 12'd0, 1'b0, 1'b0, 1'b0);

        // Reset cycle, then digit 0 showing "0".
        @(posedge clk);
        @(negedge clk);
        check8("rst_an", an4, 8'hFF);
        check8("rst_cat", cat4, 8'hFF);
        check_int("rst_busy", int'(busy4), 0);
        Reset = 1'b0;
        @(negedge clk);
        check8("post_rst_an", an4, 8'hFE);
        check8("post_rst_cat", cat4, S0);
        check_int("post_rst_busy", int'(busy4), 0);

        for (int v = 0; v < 14; v++) begin
            load_count(vecs[v].sel, vecs[v].value, vecs[v].hex, vecs[v].blank, cnt);
            check_int($sformatf("vec%0d_busy", v), cnt, vecs[v].busy);
            capture(vecs[v].sel);
            check_digits($sformatf("vec%0d", v), vecs[v].sel, vecs[v].cath);
        end

        // Load during a conversion is dropped.
        drive(0, 12'd225, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        l4  = 1'b0;
        cnt = 0;
        while (busy4 && cnt < 64) begin
            cnt++;
            if (cnt == 3) drive(0, 12'd7, 1'b0, 1'b1, 1'b1);
            else l4 = 1'b0;
            @(negedge clk);
        end
        l4 = 1'b0;
        check_int("busy_load_busy", cnt, 8);
        capture(0);
        check_digits("busy_load", 0, {BL, S2, S2, S5});

        // Load in the cycle Busy falls is rejected; one cycle later it is accepted.
        drive(0, 12'd225, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        l4 = 1'b0;
        repeat (7) @(negedge clk);
        check_int("b2b_last_busy", int'(busy4), 1);
        drive(0, 12'd7, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_int("b2b_reject", int'(busy4), 0);
        @(negedge clk);
        l4 = 1'b0;
        check_int("b2b_accept", int'(busy4), 1);
        wait_busy(0, cnt);
        check_int("b2b_busy", cnt, 8);
        capture(0);
        check_digits("b2b", 0, {BL, BL, BL, S7});

        // Scan order on the 3-digit instance: 0,1,2,0 with 4 clocks each.
        found = 1'b0;
        prev  = an3;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (an3 == 8'hFE && prev != 8'hFE) found = 1'b1;
            prev = an3;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_sync: got an %h expected fe after a digit change", an3);
        end
        for (int k = 0; k < 16; k++) begin
            exp_an = ~(8'h01 << ((k / 4) % 3));
            check8($sformatf("scan_%0d", k), an3, exp_an);
            @(negedge clk);
        end

        // Reset in the middle of a decimal conversion.
        drive(2, 12'd225, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        l3 = 1'b0;
        repeat (2) @(negedge clk);
        check_int("mid_busy", int'(busy3), 1);
        Reset = 1'b1;
        @(negedge clk);
        check_int("mid_rst_busy", int'(busy3), 0);
        check8("mid_rst_an", an3, 8'hFF);
        check8("mid_rst_cat", cat3, 8'hFF);
        Reset = 1'b0;
        @(negedge clk);
        check8("mid_post_an", an3, 8'hFE);
        check8("mid_post_cat", cat3, S0);
        check_int("mid_post_busy", int'(busy3), 0);
        capture(2);
        check_digits("mid", 2, {8'h00, S0, S0, S0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so a stuck run still ends with a failure report.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
